// File: rtl/pwm_dac_multi.sv
// Multi-channel edge-aligned PWM DAC. Signed samples arrive through a
// one-deep pending buffer and are applied to every channel at once, only
// at a period boundary, so duty never changes in the middle of a period.

// One channel: holds the active duty and drives the registered PWM pin.
module pwm_dac_lane #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 10,
    parameter bit INV    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              load,
    input  logic [DATA_W-1:0] sample,
    input  logic [CNT_W-1:0]  counter,
    output logic              pwm
);
    localparam logic [CNT_W-1:0] MID = CNT_W'(1) << (CNT_W - 1);

    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] duty_next;
    logic             unused_lsbs;

    // Offset binary: keep the top CNT_W bits and flip the sign bit, so the
    // most negative sample maps to 0 and the most positive to full scale.
    assign duty_next   = sample[DATA_W-1 -: CNT_W] ^ MID;
    // Low sample bits are truncated away on purpose.
    assign unused_lsbs = ^sample;

    // Active duty reloads only on a boundary that has a sample waiting;
    // the compare is registered, so the pin lags the counter by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= MID;
            pwm  <= 1'b0;
        end else begin
            if (load)
                duty <= duty_next;
            if (!enable)
                pwm <= 1'b0;
            else
                pwm <= (counter < duty) ^ INV;
        end
    end
endmodule

module pwm_dac_multi #(
    parameter int                    CHANNELS = 2,
    parameter int                    DATA_W   = 12,
    parameter int                    CNT_W    = 10,
    parameter logic [CHANNELS-1:0]   INVERT   = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         frame_strobe,
    output logic                         underrun
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]           counter;
    logic [CHANNELS*DATA_W-1:0] pending;
    logic                       pending_full;
    logic                       boundary;
    logic                       xfer;
    logic                       load;

    assign in_ready = !pending_full;
    assign xfer     = in_valid && in_ready;
    assign boundary = enable && (counter == CNT_MAX);
    assign load     = boundary && pending_full;

    // Shared period counter; held at zero while disabled so a re-enable
    // always starts a fresh period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            counter <= '0;
        else if (!enable)
            counter <= '0;
        else
            counter <= counter + CNT_W'(1);
    end

    // Pending buffer. A transfer needs the buffer empty, so it can never
    // collide with the boundary that drains it; a transfer that lands on
    // an empty boundary waits for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            pending_full <= 1'b0;
        end else if (load) begin
            pending_full <= 1'b0;
        end else if (xfer) begin
            pending      <= in_data;
            pending_full <= 1'b1;
        end
    end

    // Boundary pulses, visible while the counter sits at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_strobe <= boundary;
            underrun     <= boundary && !pending_full;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        pwm_dac_lane #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W),
            .INV    (INVERT[c])
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (enable),
            .load    (load),
            .sample  (pending[c*DATA_W +: DATA_W]),
            .counter (counter),
            .pwm     (pwm_out[c])
        );
    end
endmodule

// File: tb/tb_pwm_dac_multi.sv
// Directed bench for pwm_dac_multi: period 16, ch1 inverted so reset and
// disable forcing of the pin are observable against the inversion.
module tb_pwm_dac_multi;
    localparam int CH = 2;
    localparam int DW = 12;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [CH*DW-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [CH-1:0]     pwm_out;
    logic              frame_strobe;
    logic              underrun;

    int n_chk = 0;
    int n_err = 0;

    // Results of the last measured period window.
    int hi0, hi1, fs_cnt, ur_cnt;
    int s00, s01, s10, s11, rdy0, rdy1;

    always #5 clk = ~clk;

    pwm_dac_multi #(
        .CHANNELS (CH),
        .DATA_W   (DW),
        .CNT_W    (CW),
        .INVERT   (2'b10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pwm_out      (pwm_out),
        .frame_strobe (frame_strobe),
        .underrun     (underrun)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        chk("send_ready", int'(in_ready), 1);
        in_data  = {d1, d0};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Advance to the next negedge where frame_strobe is high (counter==0).
    task automatic wait_frame(output int n);
        int found;
        found = 0;
        n = 0;
        while (found == 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (frame_strobe) found = 1;
        end
        chk("frame_seen", found, 1);
    endtask

    // Sample 16 cycles starting at the current (counter==0) negedge.
    // in_valid is dropped after the first edge of the window.
    task automatic measure();
        hi0 = 0; hi1 = 0; fs_cnt = 0; ur_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            hi0    += int'(pwm_out[0]);
            hi1    += int'(pwm_out[1]);
            fs_cnt += int'(frame_strobe);
            ur_cnt += int'(underrun);
            if (i == 0) begin
                s00 = int'(pwm_out[0]); s10 = int'(pwm_out[1]); rdy0 = int'(in_ready);
            end
            if (i == 1) begin
                s01 = int'(pwm_out[0]); s11 = int'(pwm_out[1]); rdy1 = int'(in_ready);
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int n, acc0, acc1, accf, accu, accp;
        rst_n    = 1'b0;
        enable   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick(2);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_fs", int'(frame_strobe), 0);
        chk("rst_ur", int'(underrun), 0);
        chk("rst_ready", int'(in_ready), 1);
        rst_n = 1'b1;

        // Idle: midscale on both pins, underrun every boundary.
        wait_frame(n);
        chk("idle_first_boundary", n, 16);
        for (int p = 0; p < 2; p++) begin
            measure();
            chk("idle_hi0", hi0, 8);
            chk("idle_hi1", hi1, 8);
            chk("idle_fs", fs_cnt, 1);
            chk("idle_ur", ur_cnt, 1);
            wait_frame(n);
            chk("idle_period", n, 1);
        end

        // Full-scale sample mid-period: no effect until the boundary.
        tick(3);
        send(12'h7FF, 12'h800);
        chk("single_ready_lo", int'(in_ready), 0);
        acc0 = 0; acc1 = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            acc0 += int'(pwm_out[0]);
            acc1 += int'(pwm_out[1]);
        end
        chk("single_old_hi0", acc0, 5);
        chk("single_old_hi1", acc1, 7);
        wait_frame(n);
        chk("single_wait", n, 1);
        measure();
        chk("single_hi0", hi0, 15);
        chk("single_hi1", hi1, 16);
        chk("single_ur", ur_cnt, 0);
        chk("single_fs", fs_cnt, 1);
        chk("single_ready_back", rdy0, 1);
        wait_frame(n);
        measure();
        chk("single_ur_resume", ur_cnt, 1);
        chk("single_hold_hi0", hi0, 15);

        // Transfer on the boundary cycle: underrun now, applied next boundary.
        send(12'h400, 12'hC00);
        chk("coll_fs", int'(frame_strobe), 1);
        chk("coll_ur", int'(underrun), 1);
        chk("coll_ready", int'(in_ready), 0);
        wait_frame(n);
        chk("coll_wait", n, 16);
        measure();
        chk("q_hi0", hi0, 12);
        chk("q_hi1", hi1, 12);
        chk("q_ur", ur_cnt, 0);
        chk("q_edge0_c0", s00, 0);
        chk("q_edge0_c1", s01, 1);
        chk("q_edge1_c0", s10, 1);
        chk("q_edge1_c1", s11, 0);

        // Back-to-back: A (with discarded low bits) then B held on in_valid.
        tick(3);
        in_data  = {12'h600, 12'h2FF};
        in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_ready_lo", int'(in_ready), 0);
        in_data  = {12'h100, 12'hE00};
        wait_frame(n);
        chk("b2b_wait", n, 13);
        measure();
        chk("b2b_a_hi0", hi0, 10);
        chk("b2b_a_hi1", hi1, 2);
        chk("b2b_a_ur", ur_cnt, 0);
        chk("b2b_rdy_at_bnd", rdy0, 1);
        chk("b2b_b_taken", rdy1, 0);
        wait_frame(n);
        chk("b2b_gap", n, 1);
        measure();
        chk("b2b_b_hi0", hi0, 6);
        chk("b2b_b_hi1", hi1, 7);
        chk("b2b_b_ur", ur_cnt, 0);
        wait_frame(n);
        measure();
        chk("b2b_ur_after", ur_cnt, 1);

        // Enable dropped at counter 5 for 7 cycles with one sample sent.
        wait_frame(n);
        tick(5);
        enable = 1'b0;
        accp = 0; accf = 0; accu = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            accp += int'(pwm_out != 2'b00);
            accf += int'(frame_strobe);
            accu += int'(underrun);
            if (i == 1) begin
                in_data  = {12'hF00, 12'h100};
                in_valid = 1'b1;
            end
            if (i == 2) in_valid = 1'b0;
        end
        chk("dis_pwm_low", accp, 0);
        chk("dis_no_fs", accf, 0);
        chk("dis_no_ur", accu, 0);
        chk("dis_ready_lo", int'(in_ready), 0);
        enable = 1'b1;
        acc0 = 0; acc1 = 0; accf = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            acc0 += int'(pwm_out[0]);
            acc1 += int'(pwm_out[1]);
            accf += int'(frame_strobe);
        end
        chk("reen_old_hi0", acc0, 6);
        chk("reen_old_hi1", acc1, 6);
        chk("reen_no_fs", accf, 0);
        wait_frame(n);
        chk("reen_restart", n, 1);
        measure();
        chk("reen_new_hi0", hi0, 9);
        chk("reen_new_hi1", hi1, 9);
        chk("reen_ur", ur_cnt, 0);

        // Reset at counter 9 with a sample pending.
        tick(2);
        send(12'h7FF, 12'h7FF);
        chk("rst2_pending", int'(in_ready), 0);
        tick(7);
        rst_n = 1'b0;
        #1;
        chk("rst2_pwm", int'(pwm_out), 0);
        chk("rst2_ready", int'(in_ready), 1);
        chk("rst2_fs", int'(frame_strobe), 0);
        tick(2);
        chk("rst2_pwm_hold", int'(pwm_out), 0);
        rst_n = 1'b1;
        wait_frame(n);
        chk("rst2_first_bnd", n, 16);
        measure();
        chk("rst2_ur", ur_cnt, 1);
        chk("rst2_hi0", hi0, 8);
        chk("rst2_hi1", hi1, 8);
        chk("rst2_inv_s0", s10, 1);
        chk("rst2_inv_s1", s11, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
